// File: rtl/mpeg_vlc_pkg.sv
// rtl/mpeg_vlc_pkg.sv - shared widths and motion_code VLC tables
package mpeg_vlc_pkg;

    localparam int MV_BUF_W   = 11;
    localparam int MV_SHIFT_W = 5;
    localparam int MV_MAG_W   = 5;
    localparam int MV_LEN_W   = 4;

    typedef struct packed {
        logic [MV_MAG_W-1:0] mag;
        logic [MV_LEN_W-1:0] len;
    } vlc_entry_t;

    // Indexed by buf[9:7]; entry 0 is never selected.
    localparam vlc_entry_t TAB0 [8] = '{
        '{5'd0, 4'd0}, '{5'd3, 4'd3}, '{5'd2, 4'd2}, '{5'd2, 4'd2},
        '{5'd1, 4'd1}, '{5'd1, 4'd1}, '{5'd1, 4'd1}, '{5'd1, 4'd1}
    };

    // Indexed by buf[6:4]; entries 0..2 are never selected.
    localparam vlc_entry_t TAB1 [8] = '{
        '{5'd0, 4'd0}, '{5'd0, 4'd0}, '{5'd0, 4'd0}, '{5'd7, 4'd6},
        '{5'd6, 4'd6}, '{5'd5, 4'd6}, '{5'd4, 4'd5}, '{5'd4, 4'd5}
    };

    // Indexed by buf[9:1] - 12.
    localparam vlc_entry_t TAB2 [12] = '{
        '{5'd16, 4'd9}, '{5'd15, 4'd9}, '{5'd14, 4'd9}, '{5'd13, 4'd9},
        '{5'd12, 4'd9}, '{5'd11, 4'd9}, '{5'd10, 4'd8}, '{5'd10, 4'd8},
        '{5'd9,  4'd8}, '{5'd9,  4'd8}, '{5'd8,  4'd8}, '{5'd8,  4'd8}
    };

endpackage

// File: rtl/mv_vlc_lookup.sv
// rtl/mv_vlc_lookup.sv - combinational motion_code codeword to {magnitude, shift, sign, err}
module mv_vlc_lookup
    import mpeg_vlc_pkg::*;
(
    input  logic [MV_BUF_W-1:0]   bits,
    output logic [MV_MAG_W-1:0]   mag,
    output logic [MV_SHIFT_W-1:0] shift,
    output logic                  neg,
    output logic                  err
);

    logic [8:0] c9;
    logic [3:0] c_idx;
    logic [3:0] sign_pos;
    vlc_entry_t ent;

    assign c9    = bits[9:1];
    // Only evaluated for c9 in 12..23, where the low nibble minus 12 (mod 16) is 0..11.
    assign c_idx = c9[3:0] - 4'd12;

    always_comb begin
        ent = '0;
        err = 1'b0;
        if (!bits[10]) begin
            if (bits[9:7] != 3'b000) begin
                ent = TAB0[bits[9:7]];
            end else if (c9 >= 9'd24) begin
                ent = TAB1[bits[6:4]];
            end else if (c9 >= 9'd12) begin
                ent = TAB2[c_idx];
            end else begin
                err = 1'b1;
            end
        end
    end

    // The sign bit always sits right after the len-bit body that follows the marker zero.
    assign sign_pos = 4'd9 - ent.len;
    assign mag      = ent.mag;
    assign neg      = (ent.len != 4'd0) && bits[sign_pos];
    assign shift    = (ent.len == 4'd0) ? 5'd1 : ({1'b0, ent.len} + 5'd2);

endmodule

// File: rtl/get_motion_code_vlc.sv
// rtl/get_motion_code_vlc.sv - registered MPEG-2 motion_code VLC decoder
module get_motion_code_vlc
    import mpeg_vlc_pkg::*;
#(
    parameter int MCODE_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    // "buf" is a reserved gate keyword, so the window is named bitbuf.
    input  logic [MV_BUF_W-1:0]       bitbuf,
    input  logic                      in_valid,
    output logic [MV_SHIFT_W-1:0]     outshift,
    output logic signed [MCODE_W-1:0] mcode,
    output logic                      done,
    output logic                      err
);

    logic [MV_MAG_W-1:0]       lk_mag;
    logic [MV_SHIFT_W-1:0]     lk_shift;
    logic                      lk_neg;
    logic                      lk_err;
    logic [MCODE_W-1:0]        mag_w;
    logic signed [MCODE_W-1:0] mcode_nxt;

    mv_vlc_lookup u_lookup (
        .bits  (bitbuf),
        .mag   (lk_mag),
        .shift (lk_shift),
        .neg   (lk_neg),
        .err   (lk_err)
    );

    // A 5-bit result wraps +16 onto 5'b10000.
    assign mag_w     = MCODE_W'(lk_mag);
    assign mcode_nxt = lk_neg ? -$signed(mag_w) : $signed(mag_w);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outshift <= '0;
            mcode    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= in_valid;
            if (in_valid) begin
                outshift <= lk_shift;
                mcode    <= mcode_nxt;
                err      <= lk_err;
            end
        end
    end

endmodule

// File: tb/tb_get_motion_code_vlc.sv
// tb/tb_get_motion_code_vlc.sv - directed vector bench for get_motion_code_vlc
module tb_get_motion_code_vlc;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [10:0]       bitbuf = '0;
    logic [4:0]        outshift, outshift5;
    logic signed [5:0] mcode;
    logic signed [4:0] mcode5;
    logic              done, err, done5, err5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    get_motion_code_vlc #(.MCODE_W(6)) dut (
        .clk(clk), .rst(rst), .bitbuf(bitbuf), .in_valid(in_valid),
        .outshift(outshift), .mcode(mcode), .done(done), .err(err)
    );

    get_motion_code_vlc #(.MCODE_W(5)) dut5 (
        .clk(clk), .rst(rst), .bitbuf(bitbuf), .in_valid(in_valid),
        .outshift(outshift5), .mcode(mcode5), .done(done5), .err(err5)
    );

    typedef struct {
        logic [10:0] b;
        int          mc;
        int          sh;
        int          er;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic decode(input logic [10:0] b);
        @(negedge clk);
        bitbuf   = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " done"},     int'(done),     0);
        check({tag, " mcode"},    int'(mcode),    0);
        check({tag, " outshift"}, int'(outshift), 0);
        check({tag, " err"},      int'(err),      0);
    endtask

    initial begin
        logic signed [4:0] e5;
        logic [10:0]       sb [4];
        int                sm [4];
        int                ss [4];

        vecs.push_back('{11'h400,   0,  1, 0});
        vecs.push_back('{11'h200,   1,  3, 0});
        vecs.push_back('{11'h300,  -1,  3, 0});
        vecs.push_back('{11'h2FF,   1,  3, 0});
        vecs.push_back('{11'h100,   2,  4, 0});
        vecs.push_back('{11'h180,  -2,  4, 0});
        vecs.push_back('{11'h080,   3,  5, 0});
        vecs.push_back('{11'h0C0,  -3,  5, 0});
        vecs.push_back('{11'h030,   7,  8, 0});
        vecs.push_back('{11'h038,  -7,  8, 0});
        vecs.push_back('{11'h040,   6,  8, 0});
        vecs.push_back('{11'h050,   5,  8, 0});
        vecs.push_back('{11'h060,   4,  7, 0});
        vecs.push_back('{11'h070,  -4,  7, 0});
        vecs.push_back('{11'h018,  16, 11, 0});
        vecs.push_back('{11'h019, -16, 11, 0});
        vecs.push_back('{11'h020,  12, 11, 0});
        vecs.push_back('{11'h024,  10, 10, 0});
        vecs.push_back('{11'h026, -10, 10, 0});
        vecs.push_back('{11'h02E,  -8, 10, 0});
        vecs.push_back('{11'h010,   0,  1, 1});
        vecs.push_back('{11'h000,   0,  1, 1});
        vecs.push_back('{11'h017,   0,  1, 1});
        vecs.push_back('{11'h200,   1,  3, 0});

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        decode(11'h400);
        check("marker done", int'(done), 1);
        @(negedge clk);
        check("marker done drop", int'(done), 0);
        check("marker hold outshift", int'(outshift), 1);

        foreach (vecs[i]) begin
            decode(vecs[i].b);
            e5 = 5'(vecs[i].mc);
            check($sformatf("v%0d done", i),     int'(done),     1);
            check($sformatf("v%0d mcode", i),    int'(mcode),    vecs[i].mc);
            check($sformatf("v%0d outshift", i), int'(outshift), vecs[i].sh);
            check($sformatf("v%0d err", i),      int'(err),      vecs[i].er);
            check($sformatf("v%0d mcode5", i),   int'(mcode5),   int'(e5));
        end

        sb = '{11'h200, 11'h030, 11'h018, 11'h400};
        sm = '{1, 7, 16, 0};
        ss = '{3, 8, 11, 1};
        @(negedge clk);
        bitbuf   = sb[0];
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stream%0d done", k),     int'(done),     1);
            check($sformatf("stream%0d mcode", k),    int'(mcode),    sm[k]);
            check($sformatf("stream%0d outshift", k), int'(outshift), ss[k]);
            if (k < 3) bitbuf = sb[k+1];
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        check("stream end done", int'(done), 0);

        bitbuf   = 11'h200;
        in_valid = 1'b1;
        @(negedge clk);
        check("pre-reset done", int'(done), 1);
        check("pre-reset mcode", int'(mcode), 1);
        bitbuf = 11'h030;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async reset");
        bitbuf = 11'h018;
        @(negedge clk);
        check_zero("reset hold");
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_zero("after reset");

        decode(11'h024);
        check("post-reset done", int'(done), 1);
        check("post-reset mcode", int'(mcode), 10);
        check("post-reset outshift", int'(outshift), 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
